// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner:
//   state_t     - debounce FSM states
//   scan_res_t  - per-scan classification (no key / one key / several keys)
//   COL_DRIVE_* - active-low one-hot column drive patterns
//   col_drive() - column index to drive pattern
//   key_lookup()- (column index, active-low row pattern) to 4-bit key code
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DB_PRESS,
    ST_HELD,
    ST_DB_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } scan_res_t;

  localparam logic [3:0] COL_DRIVE_0 = 4'b0111;
  localparam logic [3:0] COL_DRIVE_1 = 4'b1011;
  localparam logic [3:0] COL_DRIVE_2 = 4'b1101;
  localparam logic [3:0] COL_DRIVE_3 = 4'b1110;

  function automatic logic [3:0] col_drive(input logic [1:0] col_idx);
    logic [3:0] drive;
    case (col_idx)
      2'd0:    drive = COL_DRIVE_0;
      2'd1:    drive = COL_DRIVE_1;
      2'd2:    drive = COL_DRIVE_2;
      default: drive = COL_DRIVE_3;
    endcase
    return drive;
  endfunction

  // Only meaningful for a row pattern with exactly one zero; anything
  // else falls into the last row slot and is never used by the caller.
  function automatic logic [3:0] key_lookup(input logic [1:0] col_idx,
                                            input logic [3:0] row);
    logic [1:0] row_idx;
    logic [3:0] code;
    case (row)
      4'b0111: row_idx = 2'd0;
      4'b1011: row_idx = 2'd1;
      4'b1101: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase
    case ({col_idx, row_idx})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h4;
      4'h2:    code = 4'h7;
      4'h3:    code = 4'h0;
      4'h4:    code = 4'h2;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h8;
      4'h7:    code = 4'hF;
      4'h8:    code = 4'h3;
      4'h9:    code = 4'h6;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hE;
      4'hC:    code = 4'hA;
      4'hD:    code = 4'hB;
      4'hE:    code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo
// 4-entry x 4-bit first-in first-out buffer for key events.
// Ports:
//   i_clk, i_rst_n   - clock, asynchronous active-low reset
//   i_push, i_data   - write request and key code
//   i_ready          - consumer accepts the head entry (pop when o_valid)
//   i_clr_overflow   - clears the sticky overflow flag
//   o_head, o_valid  - head entry and non-empty indication
//   o_overflow       - sticky: a push was dropped because the buffer was full
module keypad_event_fifo (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [3:0] i_data,
  input  logic       i_ready,
  input  logic       i_clr_overflow,
  output logic [3:0] o_head,
  output logic       o_valid,
  output logic       o_overflow
);

  logic [3:0] r_mem [4];
  logic [1:0] r_rd_ptr;
  logic [1:0] r_wr_ptr;
  logic [2:0] r_count;
  logic       r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_ok;
  logic w_drop;

  assign w_empty   = (r_count == 3'd0);
  assign w_full    = (r_count == 3'd4);
  assign w_pop     = !w_empty && i_ready;
  // A pop in the same cycle frees the slot, so a push into a full buffer
  // still succeeds; when full the write slot equals the slot being popped.
  assign w_push_ok = i_push && (!w_full || w_pop);
  assign w_drop    = i_push && w_full && !w_pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear request leaves the flag set.
      if (w_drop)              r_overflow <= 1'b1;
      else if (i_clr_overflow) r_overflow <= 1'b0;
    end
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_valid    = !w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scans a 4x4 active-low keypad one column at a time, classifies each full
// scan, debounces press and release over whole scans and queues one event
// per physical press in a 4-entry FIFO.
// Ports:
//   clk_100MHz, reset_n  - clock, asynchronous active-low reset
//   row                  - keypad rows, active-low, already synchronized
//   col                  - column drive, one-hot active-low
//   key_code, key_valid  - FIFO head and non-empty flag
//   key_ready            - consumer accepts the head
//   key_held             - a debounced key is currently held
//   overflow             - sticky dropped-event flag, cleared by clr_overflow
module keypad_scan_ctrl #(
  parameter int CLK_PER_COL    = 100_000,
  parameter int SETTLE         = 10,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow,
  input  logic       clr_overflow
);
  import keypad_pkg::*;

  localparam int TW = (CLK_PER_COL > 1) ? $clog2(CLK_PER_COL) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [TW-1:0] r_timer;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_col;
  scan_res_t     r_acc_res;
  logic [3:0]    r_acc_code;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cand;
  logic          r_key_held;

  logic          w_wrap;
  logic          w_sample;
  logic          w_eos;
  scan_res_t     w_row_res;
  scan_res_t     w_acc_res_next;
  logic [3:0]    w_acc_code_next;
  state_t        w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_cnt_inc;
  logic          w_cnt_done;
  logic [3:0]    w_cand_next;
  logic          w_push;

  assign w_wrap   = (r_timer == TW'(CLK_PER_COL - 1));
  assign w_sample = (r_timer == TW'(SETTLE));
  assign w_eos    = w_wrap && (r_col_idx == 2'd3);

  // Column drive is registered alongside the index so it steps on the wrap.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_timer   <= '0;
      r_col_idx <= '0;
      r_col     <= COL_DRIVE_0;
    end else if (w_wrap) begin
      r_timer   <= '0;
      r_col_idx <= r_col_idx + 2'd1;
      r_col     <= col_drive(r_col_idx + 2'd1);
    end else begin
      r_timer   <= r_timer + TW'(1);
    end
  end

  always_comb begin
    w_row_res = RES_MULTI;
    case (row)
      4'b1111:                               w_row_res = RES_NONE;
      4'b0111, 4'b1011, 4'b1101, 4'b1110:    w_row_res = RES_SINGLE;
      default:                               w_row_res = RES_MULTI;
    endcase
  end

  // A second key anywhere in the scan (same or different column) turns
  // the result into MULTI; MULTI never reverts until the next scan.
  always_comb begin
    w_acc_res_next  = r_acc_res;
    w_acc_code_next = r_acc_code;
    case (w_row_res)
      RES_SINGLE: begin
        if (r_acc_res == RES_NONE) begin
          w_acc_res_next  = RES_SINGLE;
          w_acc_code_next = key_lookup(r_col_idx, row);
        end else begin
          w_acc_res_next  = RES_MULTI;
        end
      end
      RES_MULTI: w_acc_res_next = RES_MULTI;
      default:   w_acc_res_next = r_acc_res;
    endcase
  end

  // The accumulator is cleared on the EOS edge, after the FSM has read it,
  // so every scan starts fresh at column 0.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_res  <= RES_NONE;
      r_acc_code <= '0;
    end else if (w_eos) begin
      r_acc_res  <= RES_NONE;
    end else if (w_sample) begin
      r_acc_res  <= w_acc_res_next;
      r_acc_code <= w_acc_code_next;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cand     <= '0;
      r_key_held <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_cand     <= w_cand_next;
      r_key_held <= (w_state_next == ST_HELD) || (w_state_next == ST_DB_RELEASE);
    end
  end

  assign w_cnt_inc  = (r_cnt == CW'(DEBOUNCE_SCANS)) ? r_cnt : r_cnt + CW'(1);
  assign w_cnt_done = (w_cnt_inc == CW'(DEBOUNCE_SCANS));

  // Decisions are taken only on the EOS cycle; between scans the state holds.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cand_next  = r_cand;
    w_push       = 1'b0;
    if (w_eos) begin
      case (r_state)
        ST_IDLE: begin
          if (r_acc_res == RES_SINGLE) begin
            w_cand_next  = r_acc_code;
            w_cnt_next   = CW'(1);
            w_state_next = ST_DB_PRESS;
          end
        end
        ST_DB_PRESS: begin
          if ((r_acc_res == RES_SINGLE) && (r_acc_code == r_cand)) begin
            if (w_cnt_done) begin
              w_push       = 1'b1;
              w_cnt_next   = '0;
              w_state_next = ST_HELD;
            end else begin
              w_cnt_next   = w_cnt_inc;
            end
          end else begin
            w_cnt_next   = '0;
            w_state_next = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (r_acc_res == RES_NONE) begin
            w_cnt_next   = CW'(1);
            w_state_next = ST_DB_RELEASE;
          end
        end
        default: begin
          if (r_acc_res == RES_NONE) begin
            if (w_cnt_done) begin
              w_cnt_next   = '0;
              w_state_next = ST_IDLE;
            end else begin
              w_cnt_next   = w_cnt_inc;
            end
          end else begin
            w_cnt_next   = '0;
            w_state_next = ST_HELD;
          end
        end
      endcase
    end
  end

  keypad_event_fifo u_fifo (
    .i_clk          (clk_100MHz),
    .i_rst_n        (reset_n),
    .i_push         (w_push),
    .i_data         (r_cand),
    .i_ready        (key_ready),
    .i_clr_overflow (clr_overflow),
    .o_head         (key_code),
    .o_valid        (key_valid),
    .o_overflow     (overflow)
  );

  assign col      = r_col;
  assign key_held = r_key_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
// Directed bench for keypad_scan_ctrl with a short scan (20 cycles/column,
// 3-scan debounce). A keypad model turns pressed keys into row levels from
// the column drive; expected events go into a queue that a separate monitor
// drains whenever the DUT hands an event to the consumer.
module tb_keypad_scan_ctrl;

  localparam int CPC  = 20;
  localparam int SET  = 3;
  localparam int DBS  = 3;
  localparam int SCAN = 4 * CPC;

  logic       clk_100MHz = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_held;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  logic [15:0] pressed = '0;
  logic [3:0]  expQ[$];
  int          vecCount = 0;
  int          missCount = 0;
  int          cyc = 0;
  int          base;

  always #5 clk_100MHz = ~clk_100MHz;

  keypad_scan_ctrl #(
    .CLK_PER_COL    (CPC),
    .SETTLE         (SET),
    .DEBOUNCE_SCANS (DBS)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .reset_n      (reset_n),
    .row          (row),
    .col          (col),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_held     (key_held),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // Keypad model: bit c*4+r of 'pressed' closes column c to row r
  // (row r drives row[3-r], column c is driven on col[3-c]).
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (col[3-c] == 1'b0)
        for (int r = 0; r < 4; r++)
          if (pressed[c*4+r]) row[3-r] = 1'b0;
  end

  // Bench cycle index: cycle 0 is the first cycle after reset release.
  always @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic logic [15:0] keyMask(input logic [3:0] code);
    int c;
    int r;
    c = 0; r = 0;
    case (code)
      4'h1: begin c = 0; r = 0; end
      4'h4: begin c = 0; r = 1; end
      4'h7: begin c = 0; r = 2; end
      4'h0: begin c = 0; r = 3; end
      4'h2: begin c = 1; r = 0; end
      4'h5: begin c = 1; r = 1; end
      4'h8: begin c = 1; r = 2; end
      4'hF: begin c = 1; r = 3; end
      4'h3: begin c = 2; r = 0; end
      4'h6: begin c = 2; r = 1; end
      4'h9: begin c = 2; r = 2; end
      4'hE: begin c = 2; r = 3; end
      4'hA: begin c = 3; r = 0; end
      4'hB: begin c = 3; r = 1; end
      4'hC: begin c = 3; r = 2; end
      default: begin c = 3; r = 3; end
    endcase
    return 16'h0001 << (c * 4 + r);
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task automatic goToCycle(input int target);
    while (cyc < target) @(negedge clk_100MHz);
  endtask

  // Monitor: a hand-off happens in any cycle where valid and ready are both high.
  initial begin
    forever begin
      @(negedge clk_100MHz);
      #1;
      if (reset_n && key_valid && key_ready) begin
        if (expQ.size() == 0) begin
          vecCount++;
          missCount++;
          $display("[TB] FAIL unexpected_event: actual=%h required=none (cycle %0d)", key_code, cyc);
        end else begin
          checkOutput("event_code", key_code, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk_100MHz);
    reset_n = 1'b1;

    // Reset mid-run: buffer one event with the consumer stalled, then reset.
    applyStimulus(keyMask(4'h7));
    goToCycle(3 * SCAN);
    checkOutput("prereset_valid", {3'b0, key_valid}, 4'h1);
    checkOutput("prereset_held", {3'b0, key_held}, 4'h1);
    goToCycle(3 * SCAN + 30);
    reset_n = 1'b0;
    applyStimulus('0);
    #1;
    checkOutput("reset_col", col, 4'b0111);
    checkOutput("reset_valid", {3'b0, key_valid}, 4'h0);
    checkOutput("reset_code", key_code, 4'h0);
    checkOutput("reset_held", {3'b0, key_held}, 4'h0);
    checkOutput("reset_overflow", {3'b0, overflow}, 4'h0);
    repeat (2) @(negedge clk_100MHz);
    reset_n = 1'b1;
    goToCycle(CPC - 1);
    checkOutput("col_before_step", col, 4'b0111);
    goToCycle(CPC);
    checkOutput("col_after_step", col, 4'b1011);

    // Single press of '5' for 6 scans, then release.
    base = SCAN;
    goToCycle(base);
    key_ready = 1'b1;
    expQ.push_back(4'h5);
    applyStimulus(keyMask(4'h5));
    goToCycle(base + 3 * SCAN - 1);
    checkOutput("press5_valid_early", {3'b0, key_valid}, 4'h0);
    checkOutput("press5_held_early", {3'b0, key_held}, 4'h0);
    goToCycle(base + 3 * SCAN);
    checkOutput("press5_valid_rise", {3'b0, key_valid}, 4'h1);
    checkOutput("press5_held", {3'b0, key_held}, 4'h1);
    goToCycle(base + 3 * SCAN + 1);
    checkOutput("press5_valid_fall", {3'b0, key_valid}, 4'h0);
    goToCycle(base + 6 * SCAN);
    applyStimulus('0);
    goToCycle(base + 9 * SCAN - 1);
    checkOutput("release5_held_still", {3'b0, key_held}, 4'h1);
    goToCycle(base + 9 * SCAN);
    checkOutput("release5_held_clear", {3'b0, key_held}, 4'h0);

    // Bounce on '9': 2 scans pressed, 1 open, 3 pressed.
    base = base + 10 * SCAN;
    goToCycle(base);
    expQ.push_back(4'h9);
    applyStimulus(keyMask(4'h9));
    goToCycle(base + 2 * SCAN);
    applyStimulus('0);
    goToCycle(base + 3 * SCAN);
    applyStimulus(keyMask(4'h9));
    goToCycle(base + 6 * SCAN - 1);
    checkOutput("bounce9_valid_early", {3'b0, key_valid}, 4'h0);
    goToCycle(base + 6 * SCAN);
    checkOutput("bounce9_valid_rise", {3'b0, key_valid}, 4'h1);
    applyStimulus('0);

    // Two keys together ('1' and 'A') never debounce into a press.
    base = base + 10 * SCAN;
    goToCycle(base);
    applyStimulus(keyMask(4'h1) | keyMask(4'hA));
    goToCycle(base + 3 * SCAN);
    checkOutput("multi_held_mid", {3'b0, key_held}, 4'h0);
    goToCycle(base + 6 * SCAN);
    checkOutput("multi_held_end", {3'b0, key_held}, 4'h0);
    checkOutput("multi_valid", {3'b0, key_valid}, 4'h0);
    applyStimulus('0);

    // Five presses with the consumer stalled: four buffered, fifth dropped.
    base = base + 8 * SCAN;
    key_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      goToCycle(base);
      if (k <= 4) expQ.push_back(4'(k));
      applyStimulus(keyMask(4'(k)));
      goToCycle(base + 3 * SCAN);
      if (k == 4) checkOutput("ovf_before_drop", {3'b0, overflow}, 4'h0);
      if (k == 5) checkOutput("ovf_after_drop", {3'b0, overflow}, 4'h1);
      applyStimulus('0);
      base = base + 6 * SCAN;
    end
    goToCycle(base);
    key_ready = 1'b1;
    goToCycle(base + 3);
    checkOutput("drain_valid_last", {3'b0, key_valid}, 4'h1);
    goToCycle(base + 4);
    checkOutput("drain_valid_empty", {3'b0, key_valid}, 4'h0);
    checkOutput("ovf_sticky", {3'b0, overflow}, 4'h1);
    clr_overflow = 1'b1;
    @(negedge clk_100MHz);
    clr_overflow = 1'b0;
    checkOutput("ovf_cleared", {3'b0, overflow}, 4'h0);

    // Hold '0', slide to 'F' without release, release, then press 'F'.
    base = base + SCAN;
    goToCycle(base);
    expQ.push_back(4'h0);
    applyStimulus(keyMask(4'h0));
    goToCycle(base + 4 * SCAN);
    applyStimulus(keyMask(4'hF));
    goToCycle(base + 8 * SCAN);
    checkOutput("slide_held", {3'b0, key_held}, 4'h1);
    checkOutput("slide_no_event", {3'b0, key_valid}, 4'h0);
    applyStimulus('0);
    goToCycle(base + 11 * SCAN);
    checkOutput("slide_released", {3'b0, key_held}, 4'h0);
    goToCycle(base + 12 * SCAN);
    expQ.push_back(4'hF);
    applyStimulus(keyMask(4'hF));
    goToCycle(base + 15 * SCAN);
    checkOutput("pressF_valid", {3'b0, key_valid}, 4'h1);
    applyStimulus('0);
    goToCycle(base + 19 * SCAN);

    vecCount++;
    if (expQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL events_outstanding: actual=%0d required=0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
